mport_arbiter: RTL and testbench
================================

MPORT_ARBITER -- requirements
Module: mport_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, max cycles from issue to completion.
REQ-004 SHALL have ports clk input 1, clock; rstn input 1, reset, asynchronous, active-low.
REQ-005 SHALL have, for requester N in {0,1}: rN_valid input 1, command pending; rN_mode input 1, 0 read / 1 write; rN_addr input ADDR_WIDTH; rN_wdata input DATA_WIDTH.
REQ-006 SHALL have, for N in {0,1}: rN_accept output 1, command taken pulse; rN_done output 1, completion pulse; rN_rdata output DATA_WIDTH, read data; rN_err output 1, timeout flag, valid with rN_done.
REQ-007 SHALL have master-port side: m_dvalid output 1; m_dmode output 1; m_daddr output ADDR_WIDTH; m_dwdata output DATA_WIDTH; m_dready input 1; m_drdata input DATA_WIDTH.
REQ-008 SHALL have status outputs busy output 1, FSM not IDLE; grant_id output 1, requester currently or last served.

Function
REQ-009 SHALL share one master port between requester 0 (UART bridge path) and requester 1 (local device), one transaction at a time.
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-011 IDLE: if m_dready=1 and any rN_valid=1, SHALL select a winner, latch its mode/addr/wdata, pulse rN_accept for one cycle, go ISSUE; else remain in IDLE.
REQ-012 Arbitration SHALL be round-robin: sole valid requester wins; both valid -> requester other than last_grant wins; last_grant resets to 1, so requester 0 wins first tie.
REQ-013 ISSUE: SHALL assert m_dvalid for exactly one cycle with latched m_dmode/m_daddr/m_dwdata, go WAIT_START.
REQ-014 WAIT_START: on m_dready=0 SHALL go WAIT_DONE.
REQ-015 WAIT_DONE: on m_dready=1 SHALL pulse rN_done of granted requester for one cycle, rN_rdata=m_drdata for reads, 0 for writes, rN_err=0, update last_grant, go IDLE.
REQ-016 m_daddr/m_dmode/m_dwdata SHALL hold latched values from ISSUE until next accept.
REQ-017 Timeout counter SHALL clear on entering ISSUE and increment each cycle in WAIT_START/WAIT_DONE; at TIMEOUT_CYCLES-1 SHALL pulse rN_done with rN_err=1, rN_rdata=0, update last_grant, go IDLE.
REQ-018 rN_rdata SHALL hold last value until next rN_done of that requester; the non-granted requester's done/err SHALL stay 0.
REQ-019 rN_valid deasserting after accept SHALL not affect the in-flight transaction; rN_valid asserted during busy SHALL wait (no drop, no queueing beyond one pending per requester).
REQ-020 Latency: valid (with m_dready=1, IDLE) to accept 1 cycle; accept to m_dvalid 1 cycle; m_dready rise to rN_done 1 cycle.
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 On rstn=0: state IDLE, all accept/done/err/m_dvalid 0, m_dmode 0, m_daddr 0, m_dwdata 0, rN_rdata 0, busy 0, grant_id 0, last_grant 1, counter 0.
REQ-023 Reset mid-transaction SHALL abort immediately with no done pulse after release.

Structure
REQ-024 FSM state encoding and requester ID constants (REQ_UART=0, REQ_LOCAL=1) SHALL live in shared package bus_bridge_pkg.
REQ-025 No sub-module; arbitration, FSM and timeout counter SHALL be one module instantiated between bus_bridge_master command logic and master_port.

Verification
REQ-026 r0 read addr 0x1234 alone, model returns 0xA5 after 10 cycles -> r0_accept, one m_dvalid with m_dmode=0 m_daddr=0x1234, r0_done with r0_rdata=0xA5, r0_err=0.
REQ-027 r1 write addr 0x0010 data 0x3C -> m_dmode=1 m_dwdata=0x3C, r1_done, r1_rdata=0x00.
REQ-028 r0 and r1 valid continuously for 4 transactions -> grant order 0,1,0,1; no overlapping m_dvalid.
REQ-029 TIMEOUT_CYCLES=16, model never raises m_dready -> r0_done with r0_err=1 exactly 16 cycles after issue; FSM back in IDLE.
REQ-030 rstn asserted during WAIT_DONE -> all outputs at reset values, no done pulse; next request served normally.
REQ-031 m_dready low in IDLE with r1_valid=1 -> no accept until m_dready=1, then accept next cycle.

Source files
------------

// File: rtl/bus_bridge_pkg.sv
// bus_bridge_pkg: shared FSM encoding and requester IDs for the bus bridge master port arbiter
package bus_bridge_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;
  localparam logic REQ_UART = 1'b0;
  localparam logic REQ_LOCAL = 1'b1;
endpackage

// File: rtl/mport_arbiter_if.sv
// mport_arbiter_if: two requester command ports plus the shared master port.
// slave is the arbiter's view; master is the environment's view.
interface mport_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic r0_valid, r0_mode, r0_accept, r0_done, r0_err;
  logic r1_valid, r1_mode, r1_accept, r1_done, r1_err;
  logic [ADDR_WIDTH-1:0] r0_addr, r1_addr, m_daddr;
  logic [DATA_WIDTH-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, m_dwdata, m_drdata;
  logic m_dvalid, m_dmode, m_dready;
  modport slave (
    input r0_valid, r0_mode, r0_addr, r0_wdata, r1_valid, r1_mode, r1_addr, r1_wdata,
    output r0_accept, r0_done, r0_rdata, r0_err, r1_accept, r1_done, r1_rdata, r1_err,
    output m_dvalid, m_dmode, m_daddr, m_dwdata,
    input m_dready, m_drdata
  );
  modport master (
    output r0_valid, r0_mode, r0_addr, r0_wdata, r1_valid, r1_mode, r1_addr, r1_wdata,
    input r0_accept, r0_done, r0_rdata, r0_err, r1_accept, r1_done, r1_rdata, r1_err,
    input m_dvalid, m_dmode, m_daddr, m_dwdata,
    output m_dready, m_drdata
  );
endinterface

// File: rtl/mport_arbiter.sv
// mport_arbiter: round-robin arbiter sharing one master port between two requesters,
// one transaction at a time, with a completion timeout.
module mport_arbiter import bus_bridge_pkg::*; #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic clk,
  input logic rstn,
  mport_arbiter_if.slave bus,
  output logic busy,
  output logic grant_id
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic last_q, last_d, grant_q, grant_d, busy_q, busy_d, mode_q, mode_d, dvalid_q, dvalid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d, rd;
  logic [1:0] acc_q, acc_d, done_q, done_d, err_q, err_d;
  logic win, ok;
  always_comb begin
    win = (bus.r0_valid && bus.r1_valid) ? ~last_q : (bus.r1_valid ? REQ_LOCAL : REQ_UART);
    ok = state_q == WAIT_DONE && bus.m_dready;
    rd = '0;
    state_d = state_q;
    last_d = last_q;
    grant_d = grant_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    dvalid_d = 1'b0;
    acc_d = '0;
    done_d = '0;
    err_d = '0;
    case (state_q)
      IDLE: if (bus.m_dready && (bus.r0_valid || bus.r1_valid)) begin
        state_d = ISSUE;
        grant_d = win;
        acc_d[win] = 1'b1;
        cnt_d = '0;
        mode_d = win ? bus.r1_mode : bus.r0_mode;
        addr_d = win ? bus.r1_addr : bus.r0_addr;
        wdata_d = win ? bus.r1_wdata : bus.r0_wdata;
      end
      ISSUE: begin
        dvalid_d = 1'b1;
        state_d = WAIT_START;
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (state_q == WAIT_START && !bus.m_dready) state_d = WAIT_DONE;
        // a real completion wins over a timeout landing on the same cycle
        if (ok || cnt_q == TMAX) begin
          state_d = IDLE;
          last_d = grant_q;
          done_d[grant_q] = 1'b1;
          err_d[grant_q] = !ok;
          rd = (ok && !mode_q) ? bus.m_drdata : '0;
          rdata0_d = grant_q ? rdata0_q : rd;
          rdata1_d = grant_q ? rd : rdata1_q;
        end
      end
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      last_q <= REQ_LOCAL;
      grant_q <= 1'b0;
      busy_q <= 1'b0;
      cnt_q <= '0;
      mode_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      dvalid_q <= 1'b0;
      acc_q <= '0;
      done_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      grant_q <= grant_d;
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      dvalid_q <= dvalid_d;
      acc_q <= acc_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign bus.r0_accept = acc_q[0];
  assign bus.r1_accept = acc_q[1];
  assign bus.r0_done = done_q[0];
  assign bus.r1_done = done_q[1];
  assign bus.r0_err = err_q[0];
  assign bus.r1_err = err_q[1];
  assign bus.r0_rdata = rdata0_q;
  assign bus.r1_rdata = rdata1_q;
  assign bus.m_dvalid = dvalid_q;
  assign bus.m_dmode = mode_q;
  assign bus.m_daddr = addr_q;
  assign bus.m_dwdata = wdata_q;
  assign busy = busy_q;
  assign grant_id = grant_q;
endmodule

// File: tb/tb_mport_arbiter.sv
// tb_mport_arbiter: directed stimulus with a queue scoreboard checked by a negedge monitor
module tb_mport_arbiter;
  typedef struct { logic mode; logic [15:0] addr; logic [7:0] wdata; } iss_t;
  typedef struct { logic id; logic [7:0] rdata; logic err; } done_t;
  typedef struct { logic [7:0] r; int d; } mdl_t;
  logic clk = 1'b0, rstn = 1'b0, busy, grant_id;
  logic mdl_rdy = 1'b1, force_low = 1'b0;
  logic [7:0] drdata = 8'h00;
  int checks = 0, failures = 0, cyc = 0, issue_cyc = 0, acc_cnt = 0;
  logic outstanding = 1'b0;
  logic exp_acc[$];
  iss_t exp_iss[$];
  done_t exp_done[$];
  mdl_t mdl_q[$];
  mport_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();
  mport_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .busy(busy), .grant_id(grant_id)
  );
  assign bus.m_dready = mdl_rdy && !force_low;
  assign bus.m_drdata = drdata;
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic bad(input string n);
    checks++;
    failures++;
    $display("FAIL %s", n);
  endtask
  // master port model: drop ready after a command, raise it with data after d cycles
  initial forever begin
    mdl_t m;
    @(negedge clk);
    if (bus.m_dvalid && rstn) begin
      m.r = 8'h00;
      m.d = 5;
      if (mdl_q.size() != 0) m = mdl_q.pop_front();
      mdl_rdy = 1'b0;
      repeat (m.d) @(negedge clk);
      drdata = m.r;
      mdl_rdy = 1'b1;
    end
  end
  initial forever begin
    iss_t s;
    done_t e;
    @(negedge clk);
    if (!rstn) outstanding = 1'b0;
    else begin
      if (bus.r0_accept || bus.r1_accept) begin
        acc_cnt++;
        if (exp_acc.size() == 0) bad("unexpected_accept");
        else begin
          chk("accept_id", {bus.r1_accept, bus.r0_accept}, exp_acc[0] ? 2'b10 : 2'b01);
          chk("grant_id", grant_id, exp_acc[0]);
          void'(exp_acc.pop_front());
        end
      end
      if (bus.m_dvalid) begin
        chk("dvalid_overlap", outstanding, 0);
        if (exp_iss.size() == 0) bad("unexpected_dvalid");
        else begin
          s = exp_iss.pop_front();
          chk("issue_fields", {bus.m_dmode, bus.m_daddr, bus.m_dwdata}, {s.mode, s.addr, s.wdata});
        end
        outstanding = 1'b1;
        issue_cyc = cyc;
      end
      if (bus.r0_done || bus.r1_done) begin
        if (exp_done.size() == 0) bad("unexpected_done");
        else begin
          e = exp_done.pop_front();
          chk("done_id", {bus.r1_done, bus.r0_done}, e.id ? 2'b10 : 2'b01);
          chk("done_rdata", e.id ? bus.r1_rdata : bus.r0_rdata, e.rdata);
          chk("done_err", {bus.r1_err, bus.r0_err}, e.err ? (e.id ? 2'b10 : 2'b01) : 2'b00);
          chk("done_busy", busy, 0);
          if (e.err) chk("timeout_latency", cyc - issue_cyc, 16);
        end
        outstanding = 1'b0;
      end else if (bus.r0_err || bus.r1_err) bad("err_without_done");
    end
  end
  task automatic set_req(input logic id, input logic v, input logic mode, input logic [15:0] a, input logic [7:0] wd);
    if (id) begin
      bus.r1_valid = v; bus.r1_mode = mode; bus.r1_addr = a; bus.r1_wdata = wd;
    end else begin
      bus.r0_valid = v; bus.r0_mode = mode; bus.r0_addr = a; bus.r0_wdata = wd;
    end
  endtask
  task automatic expect_txn(input logic id, input logic mode, input logic [15:0] a, input logic [7:0] wd,
                            input logic [7:0] r, input int d, input logic err, input logic with_done);
    iss_t s;
    done_t e;
    mdl_t m;
    s.mode = mode; s.addr = a; s.wdata = wd;
    e.id = id; e.rdata = (err || mode) ? 8'h00 : r; e.err = err;
    m.r = r; m.d = d;
    exp_acc.push_back(id);
    exp_iss.push_back(s);
    if (with_done) exp_done.push_back(e);
    mdl_q.push_back(m);
  endtask
  task automatic wait_acc(input logic id);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (id ? bus.r1_accept : bus.r0_accept) return;
    end
    bad("accept_wait_expired");
  endtask
  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_done.size() == 0) return;
    end
    bad("done_wait_expired");
  endtask
  task automatic wait_mdl();
    for (int i = 0; i < 100; i++) begin
      if (mdl_rdy) return;
      @(negedge clk);
    end
    bad("model_wait_expired");
  endtask
  task automatic txn(input logic id, input logic mode, input logic [15:0] a, input logic [7:0] wd,
                     input logic [7:0] r, input int d, input logic err);
    wait_mdl();
    expect_txn(id, mode, a, wd, r, d, err, 1'b1);
    set_req(id, 1'b1, mode, a, wd);
    wait_acc(id);
    set_req(id, 1'b0, 1'b0, 16'h0000, 8'h00);
    wait_done();
  endtask
  task automatic check_reset();
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_accept", {bus.r1_accept, bus.r0_accept}, 0);
    chk("rst_done", {bus.r1_done, bus.r0_done}, 0);
    chk("rst_err", {bus.r1_err, bus.r0_err}, 0);
    chk("rst_m_dvalid", bus.m_dvalid, 0);
    chk("rst_m_fields", {bus.m_dmode, bus.m_daddr, bus.m_dwdata}, 0);
    chk("rst_rdata", {bus.r1_rdata, bus.r0_rdata}, 0);
  endtask
  initial begin
    int base;
    set_req(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (3) @(negedge clk);
    check_reset();
    rstn = 1'b1;
    @(negedge clk);
    txn(1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 10, 1'b0);
    txn(1'b1, 1'b1, 16'h0010, 8'h3C, 8'hEE, 3, 1'b0);
    // both requesters held valid: last grant was 1, so order must be 0,1,0,1
    wait_mdl();
    expect_txn(1'b0, 1'b0, 16'h2000, 8'h00, 8'h11, 2, 1'b0, 1'b1);
    expect_txn(1'b1, 1'b1, 16'h3000, 8'h5A, 8'h22, 2, 1'b0, 1'b1);
    expect_txn(1'b0, 1'b0, 16'h2000, 8'h00, 8'h33, 2, 1'b0, 1'b1);
    expect_txn(1'b1, 1'b1, 16'h3000, 8'h5A, 8'h44, 2, 1'b0, 1'b1);
    base = acc_cnt;
    set_req(1'b0, 1'b1, 1'b0, 16'h2000, 8'h00);
    set_req(1'b1, 1'b1, 1'b1, 16'h3000, 8'h5A);
    for (int i = 0; i < 300 && acc_cnt < base + 4; i++) @(negedge clk);
    if (acc_cnt < base + 4) bad("rr_accept_wait_expired");
    set_req(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    wait_done();
    txn(1'b0, 1'b0, 16'h0BAD, 8'h00, 8'h77, 30, 1'b1);
    chk("after_timeout_rdata", bus.r0_rdata, 0);
    // reset while waiting for completion: no done may follow
    wait_mdl();
    expect_txn(1'b0, 1'b0, 16'h4444, 8'h00, 8'h99, 10, 1'b0, 1'b0);
    set_req(1'b0, 1'b1, 1'b0, 16'h4444, 8'h00);
    wait_acc(1'b0);
    set_req(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    for (int i = 0; i < 10 && !outstanding; i++) @(negedge clk);
    chk("abort_issued", outstanding, 1);
    repeat (4) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rstn = 1'b0;
    @(negedge clk);
    check_reset();
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    txn(1'b0, 1'b0, 16'h0042, 8'h00, 8'h5C, 2, 1'b0);
    // master port not ready in IDLE: requester must wait
    wait_mdl();
    force_low = 1'b1;
    set_req(1'b1, 1'b1, 1'b0, 16'h0777, 8'h00);
    repeat (5) begin
      @(negedge clk);
      chk("hold_no_accept", bus.r1_accept, 0);
    end
    expect_txn(1'b1, 1'b0, 16'h0777, 8'h00, 8'h6B, 4, 1'b0, 1'b1);
    force_low = 1'b0;
    @(negedge clk);
    chk("accept_one_cycle", bus.r1_accept, 1);
    set_req(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    wait_done();
    repeat (5) @(negedge clk);
    chk("final_queues_empty", exp_acc.size() + exp_iss.size() + exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end
endmodule
